// File: rtl/credit_returner.sv
// credit_returner: coalesces freed buffer slots into batched credit returns; offer 1 cycle after BATCH/flush, held stable under ret_ready backpressure.
// CREDIT_RETURNER_TIMEOUT_EN adds a timer that forces out sub-BATCH residue TIMEOUT cycles after it starts accumulating.
module credit_returner #(
  parameter int RANGE   = 4,
  parameter int BATCH   = 2,
  parameter int TIMEOUT = 8,
  localparam int CW     = $clog2(RANGE + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          free,
  input  logic          flush,
  output logic          ret_valid,
  output logic [CW-1:0] ret_count,
  input  logic          ret_ready,
  output logic [CW-1:0] pending,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, OFFER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [CW-1:0] snap_q, snap_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] pend_sub;
  logic          free_ok;
  logic          accept;
  logic          timeout_hit;

  assign accept = (state_q == OFFER) && ret_ready;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    pend_sub   = accept ? (pend_q - snap_q) : pend_q;
    // A free is only lost when the pool is full and nothing leaves this cycle.
    free_ok    = free && (pend_sub != CW'(RANGE));
    pend_d     = pend_sub + CW'(free_ok);
    overflow_d = overflow_q | (free & ~free_ok);
    unique case (state_q)
      IDLE: begin
        if (free) begin
          if (pend_d >= CW'(BATCH)) begin
            state_d = OFFER;
            snap_d  = pend_d;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if ((pend_d >= CW'(BATCH)) || flush || timeout_hit) begin
          state_d = OFFER;
          snap_d  = pend_d;
        end
      end
      OFFER: begin
        if (accept) begin
          if (pend_d >= CW'(BATCH)) begin
            snap_d = pend_d;
          end else begin
            snap_d  = '0;
            state_d = (pend_d != '0) ? ACCUM : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        snap_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      snap_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CREDIT_RETURNER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer_q, timer_d;

  // Timer only runs while residue sits in ACCUM; any exit restarts it at 0.
  always_comb begin
    timer_d = '0;
    if ((state_q == ACCUM) && (state_d == ACCUM)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout_hit = (state_q == ACCUM) && (timer_q == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign ret_valid = (state_q == OFFER);
  assign ret_count = snap_q;
  assign pending   = pend_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_credit_returner.sv
// Directed bench for credit_returner; accepted offers are checked against a queue of expected batch sizes.
module tb_credit_returner;
  localparam int RANGE   = 4;
  localparam int BATCH   = 2;
  localparam int TIMEOUT = 8;
  localparam int CW      = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          free;
  logic          flush;
  logic          ret_ready;
  logic          ret_valid;
  logic [CW-1:0] ret_count;
  logic [CW-1:0] pending;
  logic          overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int early;
  int held_bad;
  int exp_q[$];

  credit_returner #(
    .RANGE  (RANGE),
    .BATCH  (BATCH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .free     (free),
    .flush    (flush),
    .ret_valid(ret_valid),
    .ret_count(ret_count),
    .ret_ready(ret_ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    free      = 1'b0;
    flush     = 1'b0;
    ret_ready = 1'b0;
    exp_q.delete();
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  // Inputs are stable at negedge, so a handshake seen here is the one the next posedge takes.
  always @(negedge clk) begin
    if (rstn === 1'b1 && ret_valid === 1'b1 && ret_ready === 1'b1) begin
      n_accept++;
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("sb_ret_count", ret_count, exp_q.pop_front());
      end
    end
  end

  initial begin
    rstn      = 1'b0;
    free      = 1'b0;
    flush     = 1'b0;
    ret_ready = 1'b0;
    tick(2);
    chk("rst_valid", ret_valid, 0);
    chk("rst_count", ret_count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    rstn = 1'b1;
    tick(1);

    // Two frees reach BATCH; offer the next cycle, accepted at once.
    ret_ready = 1'b1;
    free = 1'b1;
    tick();
    chk("t1_pend1", pending, 1);
    chk("t1_valid_early", ret_valid, 0);
    exp_q.push_back(2);
    tick();
    chk("t1_valid", ret_valid, 1);
    chk("t1_count", ret_count, 2);
    free = 1'b0;
    tick();
    chk("t1_idle_valid", ret_valid, 0);
    chk("t1_idle_pend", pending, 0);

    // Backpressure with continuous frees, saturation, then back-to-back drain.
    ret_ready = 1'b0;
    free = 1'b1;
    tick();
    exp_q.push_back(2);
    tick();
    chk("t2_count", ret_count, 2);
    tick();
    chk("t2_pend3", pending, 3);
    chk("t2_hold1", ret_count, 2);
    tick();
    chk("t2_pend4", pending, 4);
    chk("t2_no_ovf", overflow, 0);
    tick();
    chk("t2_ovf", overflow, 1);
    chk("t2_pend_sat", pending, 4);
    chk("t2_hold2", ret_count, 2);
    chk("t2_valid_held", ret_valid, 1);
    free = 1'b0;
    ret_ready = 1'b1;
    exp_q.push_back(2);
    tick();
    chk("t2_b2b_valid", ret_valid, 1);
    chk("t2_b2b_count", ret_count, 2);
    chk("t2_b2b_pend", pending, 2);
    tick();
    chk("t2_drain_valid", ret_valid, 0);
    chk("t2_drain_pend", pending, 0);
    chk("t2_ovf_sticky", overflow, 1);
    do_reset();
    chk("t2_ovf_cleared", overflow, 0);

    // Lone free: timeout-forced offer, or indefinite wait and flush.
    ret_ready = 1'b1;
    free = 1'b1;
    tick();
    free = 1'b0;
    early = 0;
`ifdef CREDIT_RETURNER_TIMEOUT_EN
    repeat (7) begin
      tick();
      if (ret_valid !== 1'b0) early++;
    end
    chk("t3_no_early_offer", early, 0);
    exp_q.push_back(1);
    tick();
    chk("t3_timeout_valid", ret_valid, 1);
    chk("t3_timeout_count", ret_count, 1);
`else
    repeat (100) begin
      tick();
      if (ret_valid !== 1'b0) early++;
    end
    chk("t3_no_offer", early, 0);
    chk("t3_residue", pending, 1);
    flush = 1'b1;
    exp_q.push_back(1);
    tick();
    flush = 1'b0;
    chk("t3_flush_valid", ret_valid, 1);
    chk("t3_flush_count", ret_count, 1);
`endif
    tick();
    chk("t3_idle_pend", pending, 0);
    chk("t3_idle_valid", ret_valid, 0);

    // Flush in IDLE does nothing; flush in ACCUM offers the residue.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_idle", ret_valid, 0);
    free = 1'b1;
    tick();
    free = 1'b0;
    flush = 1'b1;
    exp_q.push_back(1);
    tick();
    flush = 1'b0;
    chk("t3_flush_accum_valid", ret_valid, 1);
    chk("t3_flush_accum_count", ret_count, 1);
    tick();
    chk("t3_flush_accum_done", ret_valid, 0);

    // Offer stalled five cycles with a free inside the window.
    ret_ready = 1'b0;
    free = 1'b1;
    tick();
    exp_q.push_back(2);
    tick();
    held_bad = 0;
    for (int i = 0; i < 5; i++) begin
      free = (i == 1);
      tick();
      if (ret_count !== 3'd2 || ret_valid !== 1'b1) held_bad++;
    end
    free = 1'b0;
    chk("t4_held_stable", held_bad, 0);
    chk("t4_pend3", pending, 3);
    ret_ready = 1'b1;
    tick();
    chk("t4_accum_valid", ret_valid, 0);
    chk("t4_accum_pend", pending, 1);
`ifdef CREDIT_RETURNER_TIMEOUT_EN
    early = 0;
    repeat (7) begin
      tick();
      if (ret_valid !== 1'b0) early++;
    end
    chk("t4_timer_restart", early, 0);
    exp_q.push_back(1);
    tick();
    chk("t4_timeout_valid", ret_valid, 1);
`else
    flush = 1'b1;
    exp_q.push_back(1);
    tick();
    flush = 1'b0;
    chk("t4_flush_valid", ret_valid, 1);
`endif
    chk("t4_residue_count", ret_count, 1);
    tick();
    chk("t4_done_pend", pending, 0);

    // Free coinciding with acceptance: 2 accepted, 1 arrives -> pend 1, ACCUM.
    ret_ready = 1'b0;
    free = 1'b1;
    tick();
    exp_q.push_back(2);
    tick();
    chk("t5_pre_pend", pending, 2);
    ret_ready = 1'b1;
    tick();
    free = 1'b0;
    chk("t5_pend1", pending, 1);
    chk("t5_accum", ret_valid, 0);
    flush = 1'b1;
    exp_q.push_back(1);
    tick();
    flush = 1'b0;
    chk("t5_flush_count", ret_count, 1);
    tick();
    chk("t5_done_pend", pending, 0);

    // pend 3, snap 2, free + accept -> pend stays 2 and re-offers.
    ret_ready = 1'b0;
    free = 1'b1;
    tick();
    exp_q.push_back(2);
    tick(2);
    chk("t5b_pend3", pending, 3);
    ret_ready = 1'b1;
    exp_q.push_back(2);
    tick();
    free = 1'b0;
    chk("t5b_pend_const", pending, 2);
    chk("t5b_reoffer_valid", ret_valid, 1);
    chk("t5b_reoffer_count", ret_count, 2);
    tick();
    chk("t5b_idle", pending, 0);

    // Asynchronous reset in the middle of a stalled, overflowed offer.
    ret_ready = 1'b0;
    free = 1'b1;
    tick(5);
    free = 1'b0;
    chk("t6_pre_valid", ret_valid, 1);
    chk("t6_pre_ovf", overflow, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", ret_valid, 0);
    chk("t6_async_pend", pending, 0);
    chk("t6_async_ovf", overflow, 0);
    chk("t6_async_count", ret_count, 0);
    exp_q.delete();
    tick();
    rstn = 1'b1;
    tick();
    ret_ready = 1'b1;
    free = 1'b1;
    tick();
    exp_q.push_back(2);
    tick();
    free = 1'b0;
    chk("t6_resume_valid", ret_valid, 1);
    chk("t6_resume_count", ret_count, 2);
    tick();
    chk("t6_resume_idle", pending, 0);

    tick(2);
    chk("sb_drained", exp_q.size(), 0);
    chk("accept_total", n_accept, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
